// File: rtl/gullfaxi_arbiter.sv
// gullfaxi_arbiter
//   Round-robin arbiter that lets NREQ Gullfaxi requesters share one output
//   link. A requester raises in_req, receives a one-cycle in_grant pulse, and
//   must then start its packet within TIMEOUT cycles. The owner's beats are
//   forwarded to out_* with one cycle of registered latency. Protocol
//   violations (start timeout, end/length disagreement) raise a one-cycle err
//   pulse and return the arbiter to IDLE.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_req     in   [NREQ]    request per requester
//   in_grant   out  [NREQ]    one-cycle grant pulse, at most one bit set
//   in_start   in   [NREQ]    first beat marker per requester
//   in_end     in   [NREQ]    last beat marker per requester
//   in_length  in   [NREQ*6]  packet length, 6 bits per requester
//   in_data    in   [NREQ*8]  beat data, 8 bits per requester
//   out_valid  out  forwarded beat present
//   out_start  out  forwarded first-beat marker
//   out_end    out  forwarded last-beat marker
//   out_data   out  [8] forwarded beat data
//   out_length out  [6] length of the packet in flight
//   owner      out  [2] current or most recently granted requester
//   busy       out  high in every state except IDLE
//   err        out  one-cycle protocol violation pulse
module gullfaxi_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   in_req,
  output logic [NREQ-1:0]   in_grant,
  input  logic [NREQ-1:0]   in_start,
  input  logic [NREQ-1:0]   in_end,
  input  logic [NREQ*6-1:0] in_length,
  input  logic [NREQ*8-1:0] in_data,
  output logic              out_valid,
  output logic              out_start,
  output logic              out_end,
  output logic [7:0]        out_data,
  output logic [5:0]        out_length,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, BUSY} state_t;

  state_t          state, state_nx;
  logic [1:0]      owner_nx, last_owner, last_owner_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [5:0]      beat_cnt, beat_cnt_nx;
  logic [6:0]      beat_now;
  logic            sel_start, sel_end;
  logic [5:0]      sel_len;
  logic [7:0]      sel_data;
  logic            hi_found, lo_found;
  logic [1:0]      hi_idx, lo_idx, winner;
  logic            fwd, viol;

  // Only the owner's side-band and data are ever looked at.
  always_comb begin
    sel_start = 1'b0;
    sel_end   = 1'b0;
    sel_len   = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(owner) == i) begin
        sel_start = in_start[i];
        sel_end   = in_end[i];
        sel_len   = in_length[6*i +: 6];
        sel_data  = in_data[8*i +: 8];
      end
    end
  end

  // Round-robin: prefer the lowest requester above last_owner, otherwise
  // wrap around to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (in_req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = 2'(i);
      end
      if (in_req[i] && !hi_found && (i > int'(last_owner))) begin
        hi_found = 1'b1;
        hi_idx   = 2'(i);
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  // Next-state logic
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    tcnt_nx       = tcnt;
    beat_cnt_nx   = beat_cnt;
    fwd           = 1'b0;
    viol          = 1'b0;
    // Beat number of the beat being presented this cycle while in BUSY.
    beat_now      = {1'b0, beat_cnt} + 7'd1;
    case (state)
      IDLE: begin
        if (|in_req) begin
          state_nx      = GRANT;
          owner_nx      = winner;
          last_owner_nx = winner;
        end
      end
      GRANT: begin
        state_nx = WAIT_START;
        tcnt_nx  = '0;
      end
      WAIT_START: begin
        tcnt_nx = tcnt + 1'b1;
        if (sel_start) begin
          fwd         = 1'b1;
          beat_cnt_nx = 6'd1;
          if (sel_end) begin
            state_nx = IDLE;
            viol     = (sel_len != 6'd1);
          end else begin
            state_nx = BUSY;
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          // Last allowed cycle for the start beat has passed.
          viol     = 1'b1;
          state_nx = IDLE;
        end
      end
      BUSY: begin
        fwd         = 1'b1;
        beat_cnt_nx = beat_cnt + 1'b1;
        if (sel_end) begin
          state_nx = IDLE;
          viol     = (beat_now != {1'b0, sel_len});
        end else if (beat_now >= {1'b0, sel_len}) begin
          // Declared length used up without an end marker.
          viol     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= 2'(NREQ - 1);
      tcnt       <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      tcnt       <= tcnt_nx;
      beat_cnt   <= beat_cnt_nx;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    in_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state == GRANT) && (int'(owner) == i)) in_grant[i] = 1'b1;
    end
    busy = (state != IDLE);
  end

  // Forwarding stage: owner beat -> out_* one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_start  <= 1'b0;
      out_end    <= 1'b0;
      out_data   <= '0;
      out_length <= '0;
      err        <= 1'b0;
    end else begin
      out_valid  <= fwd;
      out_start  <= fwd & sel_start;
      out_end    <= fwd & sel_end;
      out_data   <= fwd ? sel_data : 8'd0;
      out_length <= fwd ? sel_len : 6'd0;
      err        <= viol;
    end
  end

endmodule

// File: tb/tb_gullfaxi_arbiter.sv
// Testbench for gullfaxi_arbiter. Stimulus is organised as whole packets; a
// transaction-level model derives, cycle by cycle, what every output must be,
// and a single negedge process compares the DUT against it.
module tb_gullfaxi_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   in_req, in_grant, in_start, in_end;
  logic [NREQ*6-1:0] in_length;
  logic [NREQ*8-1:0] in_data;
  logic              out_valid, out_start, out_end, busy, err;
  logic [7:0]        out_data;
  logic [5:0]        out_length;
  logic [1:0]        owner;

  gullfaxi_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_grant(in_grant),
    .in_start(in_start), .in_end(in_end), .in_length(in_length),
    .in_data(in_data), .out_valid(out_valid), .out_start(out_start),
    .out_end(out_end), .out_data(out_data), .out_length(out_length),
    .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [1:0]      owner;
    logic            err;
    logic            ov, os, oe;
    logic [7:0]      od;
    logic [5:0]      ol;
  } exp_t;

  exp_t exp_now, nx, act;
  logic chk_en = 1'b0;
  int   checks = 0, errors = 0;
  int   beats_seen = 0, errs_seen = 0;
  int   glog[$];
  int   m_owner, m_last;

  function automatic exp_t mk(input logic [NREQ-1:0] g, input logic b, input int own,
                              input logic e, input logic v, input logic s, input logic en,
                              input logic [7:0] d, input logic [5:0] l);
    exp_t x;
    x.grant = g; x.busy = b; x.owner = 2'(own); x.err = e;
    x.ov = v; x.os = s; x.oe = en; x.od = d; x.ol = l;
    return x;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Round-robin from the rule: first requester found at last+1, last+2, ...
  function automatic int rr(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      logic [NREQ-1:0] t;
      idx = (last + k) % NREQ;
      t = r >> idx;
      if (t[0]) return idx;
    end
    return -1;
  endfunction

  task automatic check_int(input string name, input int a, input int r);
    checks++;
    if (a != r) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, a, r);
    end
  endtask

  // Single compare process for the whole output bundle
  always @(negedge clk) begin
    if (chk_en) begin
      act = {in_grant, busy, owner, err, out_valid, out_start, out_end, out_data, out_length};
      checks++;
      if (act !== exp_now) begin
        errors++;
        $display("FAIL outputs t=%0t actual(grant=%b busy=%b owner=%0d err=%b v=%b s=%b e=%b d=%h l=%0d) required(grant=%b busy=%b owner=%0d err=%b v=%b s=%b e=%b d=%h l=%0d)",
                 $time, act.grant, act.busy, act.owner, act.err, act.ov, act.os, act.oe, act.od, act.ol,
                 exp_now.grant, exp_now.busy, exp_now.owner, exp_now.err, exp_now.ov, exp_now.os,
                 exp_now.oe, exp_now.od, exp_now.ol);
      end
      checks++;
      if ($countones(in_grant) > 1) begin
        errors++;
        $display("FAIL grant_onehot actual=%b required=at most one bit", in_grant);
      end
      if (out_valid === 1'b1) beats_seen++;
      if (err === 1'b1) errs_seen++;
      for (int i = 0; i < NREQ; i++) if (in_grant[i] === 1'b1) glog.push_back(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_now = nx;
  endtask

  task automatic drive_junk(input int quiet);
    for (int i = 0; i < NREQ; i++) begin
      in_start[i] = 1'($urandom_range(0, 1));
      in_end[i]   = 1'($urandom_range(0, 1));
      in_length[i*6 +: 6] = 6'($urandom);
      in_data[i*8 +: 8]   = 8'($urandom);
    end
    if (quiet >= 0) begin
      in_start[quiet] = 1'b0;
      in_end[quiet]   = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    in_req = '0;
    drive_junk(-1);
    nx = mk('0, 0, m_owner, 0, 0, 0, 0, 8'd0, 6'd0);
    tick();
  endtask

  // One packet, entered and left in an IDLE cycle. d: start delay in wait
  // cycles (>= TIMEOUT means never). endbeat: beat carrying end (0 = none).
  // abort_at: beat number at which reset is asserted (0 = never).
  task automatic run_packet(input logic [NREQ-1:0] req, input int d, input int len,
                            input int endbeat, input int abort_at);
    int w;
    logic [7:0] dat;
    logic fin, e;
    w = rr(req, m_last);
    drive_junk(-1);
    in_req = req;
    m_owner = w;
    m_last  = w;
    nx = mk(onehot(w), 1, w, 0, 0, 0, 0, 8'd0, 6'd0);
    tick();
    // grant cycle: everything ignored
    drive_junk(-1);
    in_req = NREQ'($urandom);
    nx = mk('0, 1, w, 0, 0, 0, 0, 8'd0, 6'd0);
    tick();
    for (int t = 0; t < TIMEOUT; t++) begin
      if (t == d) break;
      drive_junk(w);
      in_req = NREQ'($urandom);
      if (t == TIMEOUT - 1) begin
        nx = mk('0, 0, w, 1, 0, 0, 0, 8'd0, 6'd0);
        tick();
        in_req = '0;
        drive_junk(-1);
        return;
      end
      nx = mk('0, 1, w, 0, 0, 0, 0, 8'd0, 6'd0);
      tick();
    end
    for (int b = 1; b <= 64; b++) begin
      if (b == abort_at) begin
        reset   = 1'b0;
        exp_now = mk('0, 0, 0, 0, 0, 0, 0, 8'd0, 6'd0);
        nx      = exp_now;
        in_req  = '0;
        drive_junk(-1);
        m_owner = 0;
        m_last  = NREQ - 1;
        tick();
        tick();
        reset = 1'b1;
        return;
      end
      drive_junk(w);
      in_req = NREQ'($urandom);
      dat = 8'($urandom);
      in_start[w] = (b == 1);
      in_end[w]   = (b == endbeat);
      in_length[w*6 +: 6] = 6'(len);
      in_data[w*8 +: 8]   = dat;
      fin = (b == endbeat) || (b >= 2 && b >= len);
      e   = ((b == endbeat) && (b != len)) || ((b != endbeat) && b >= 2 && b >= len);
      nx = mk('0, !fin, w, e, 1, (b == 1), (b == endbeat), dat, 6'(len));
      tick();
      if (fin) break;
    end
    in_req = '0;
    drive_junk(-1);
  endtask

  initial begin
    int b0, e0, req, d, len, eb, mode;
    reset = 1'b1;
    in_req = '0; in_start = '0; in_end = '0; in_length = '0; in_data = '0;
    m_owner = 0;
    m_last  = NREQ - 1;
    exp_now = mk('0, 0, 0, 0, 0, 0, 0, 8'd0, 6'd0);
    nx = exp_now;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_junk(-1);
    reset = 1'b1;

    // Model pins
    check_int("rr_from_reset", rr(3'b111, 2), 0);
    check_int("rr_wrap", rr(3'b011, 1), 0);

    // All requesting: order 0,1,2,0
    repeat (4) run_packet(3'b111, 0, 3, 3, 0);
    idle_cycle();
    check_int("grant_log_size", glog.size(), 4);
    if (glog.size() >= 4) begin
      check_int("grant_order_0", glog[0], 0);
      check_int("grant_order_1", glog[1], 1);
      check_int("grant_order_2", glog[2], 2);
      check_int("grant_order_3", glog[3], 0);
    end

    // Single requester, length 4
    b0 = beats_seen; e0 = errs_seen;
    run_packet(3'b001, 1, 4, 4, 0);
    idle_cycle();
    check_int("len4_beats", beats_seen - b0, 4);
    check_int("len4_err", errs_seen - e0, 0);

    // Length-1 packet
    b0 = beats_seen;
    run_packet(3'b010, 0, 1, 1, 0);
    idle_cycle();
    check_int("len1_beats", beats_seen - b0, 1);

    // Start timeout, then the other requester is served
    e0 = errs_seen;
    run_packet(3'b011, TIMEOUT + 2, 4, 4, 0);
    run_packet(3'b011, 2, 2, 2, 0);
    idle_cycle();
    check_int("timeout_err", errs_seen - e0, 1);
    check_int("after_timeout_grant", glog[glog.size() - 1], 1);

    // Early end
    e0 = errs_seen;
    run_packet(3'b001, 0, 5, 3, 0);
    idle_cycle();
    check_int("early_end_err", errs_seen - e0, 1);

    // Reset mid-packet, then requester 2 alone
    e0 = errs_seen;
    run_packet(3'b001, 0, 6, 6, 3);
    run_packet(3'b100, 1, 2, 2, 0);
    idle_cycle();
    check_int("reset_no_err", errs_seen - e0, 0);
    check_int("after_reset_grant", glog[glog.size() - 1], 2);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      req = $urandom_range(1, (1 << NREQ) - 1);
      d   = ($urandom_range(0, 5) == 0) ? TIMEOUT + $urandom_range(0, 2)
                                        : $urandom_range(0, TIMEOUT - 1);
      len  = $urandom_range(1, 12);
      mode = $urandom_range(0, 2);
      eb   = len;
      if (mode == 1 && len >= 2) eb = $urandom_range(1, len - 1);
      if (mode == 2 && len >= 2) eb = 0;
      run_packet(NREQ'(req), d, len, eb, 0);
    end
    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gullfaxi_arbiter.md
GULLFAXI_ARBITER -- requirements
Module: gullfaxi_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of Gullfaxi output ports (requesters) sharing one link; legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT, default 8: maximum cycles from grant to first beat.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1: clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_req  input  NREQ: bit i is request from requester i.
REQ-007 SHALL have port in_grant  output  NREQ: bit i is grant to requester i.
REQ-008 SHALL have port in_start  input  NREQ: first beat of requester i.
REQ-009 SHALL have port in_end  input  NREQ: last beat of requester i.
REQ-010 SHALL have port in_length  input  NREQ*6: packet length, bits [6i+5:6i] belong to requester i.
REQ-011 SHALL have port in_data  input  NREQ*8: beat data, bits [8i+7:8i] belong to requester i.
REQ-012 SHALL have port out_valid  output  1: out_data holds a beat this cycle.
REQ-013 SHALL have port out_start  output  1: first beat of a packet.
REQ-014 SHALL have port out_end  output  1: last beat of a packet.
REQ-015 SHALL have port out_data  output  8: forwarded beat.
REQ-016 SHALL have port out_length  output  6: length of the packet in flight.
REQ-017 SHALL have port owner  output  2: index of the current or last granted requester.
REQ-018 SHALL have port busy  output  1: high in every state except IDLE.
REQ-019 SHALL have port err  output  1: one-cycle pulse on a protocol violation.

Function
REQ-020 SHALL implement the states IDLE, GRANT, WAIT_START and BUSY.
REQ-021 SHALL, in IDLE with any in_req bit high, select a winner by round-robin, searching from (last_owner+1) mod NREQ upward and wrapping; it SHALL load owner and last_owner with the winner and go to GRANT.
REQ-022 SHALL, in GRANT, register in_grant[owner]=1 for exactly one cycle, with all other grant bits 0, and go to WAIT_START with the timeout counter cleared.
REQ-023 SHALL, in WAIT_START, increment the timeout counter every cycle.
REQ-024 SHALL, in WAIT_START with in_start[owner]=1, forward the beat, clear the beat counter to 1 and go to BUSY; if in_end[owner] is also 1 (length-1 packet), it SHALL go to IDLE instead.
REQ-025 SHALL, in WAIT_START when the timeout counter reaches TIMEOUT with no start, pulse err and go to IDLE.
REQ-026 SHALL, in BUSY, forward one beat per cycle and increment the beat counter (6 bits).
REQ-027 SHALL, in BUSY, go to IDLE when in_end[owner]=1.
REQ-028 SHALL pulse err if, in BUSY, the beat counter reaches in_length[owner] without in_end; it SHALL also go to IDLE in that case.
REQ-029 SHALL pulse err if in_end[owner] arrives with a beat count not equal to in_length[owner].
REQ-030 SHALL forward each beat with one cycle of registered latency: out_valid/out_start/out_end/out_data/out_length take the owner's values; out_* SHALL be 0 when no beat is forwarded.
REQ-031 SHALL ignore in_start, in_end, in_data and in_length of non-owners.
REQ-032 SHALL ignore in_req in every state except IDLE; requests are not queued, and losers keep req high until granted.
REQ-033 SHALL be able to re-arbitrate in the cycle after IDLE is re-entered; the minimum gap between packets is a consequence of the GRANT and WAIT_START states.
REQ-034 SHALL never assert more than one in_grant bit in the same cycle.

Reset
REQ-035 SHALL, while reset=0: set all outputs to 0, state to IDLE, counters to 0, owner to 0, and last_owner to NREQ-1 (so requester 0 wins first).
REQ-036 SHALL, on reset assertion mid-packet, abandon the packet immediately with no err pulse.

Verification
REQ-037 Scenario: req=3'b001, router sends length 4 -> grant[0] pulses once; 4 out beats with start on beat 1 and end on beat 4; out_length=4; err=0.
REQ-038 Scenario: req=3'b111 held and all routers behave -> grant order 0,1,2,0; owner follows the same order.
REQ-039 Scenario: length-1 packet (start and end in the same cycle) -> one out beat with out_start=out_end=1; arbiter returns to IDLE.
REQ-040 Scenario: grant issued but no start for 8 cycles -> err pulses once, busy falls, next requester is served.
REQ-041 Scenario: length=5 but end on beat 3 -> err pulse, IDLE; non-owner start toggling during BUSY never reaches out_*.
REQ-042 Scenario: reset=0 asserted during BUSY -> all outputs 0 immediately; after release, req=3'b100 is granted normally.
